// File: rtl/baud_gen_arbiter.sv
// ---------------------------------------------------------------------------
// baud_gen_arbiter
//
// Shares one baud clock generator (clk_gen) among NUM_REQ UART channel
// controllers. A round-robin arbiter picks an owner. The owner's requested
// baud is programmed onto the generator while the generator is held in reset.
// After SETTLE_EDGES rising edges of the returned tx_clk, ready is raised.
// It stays up until the owner releases, drops its request, changes its baud,
// or is preempted by the optional hold limit.
//
// Handshake: a requester raises req_i[i] and keeps it high while it wants the
// generator. grant_o[i] marks it as owner. The baud is only usable while
// ready_o=1. The owner ends ownership with a one-cycle release_i[i] pulse or
// by dropping req_i[i]. grant_o and ready_o then fall together on the next
// clock edge.
//
// Ports:
//   clk            system clock
//   rst            synchronous active-high reset
//   req_i          level request per requester
//   release_i      one-cycle release pulse per requester (owner only)
//   req_baud_i     requested baud, requester i at [17*i+16:17*i]
//   gen_tx_clk_i   tx_clk returned from the generator
//   gen_baud_o     baud driven to the generator
//   gen_rst_o      generator reset (active high)
//   grant_o        one-hot owner (registered)
//   ready_o        generator settled at the owner's baud
//   timeout_err_o  one-cycle pulse: owner preempted by the hold limit
//   state_o        FSM state (0 IDLE, 1 PROG, 2 SETTLE, 3 OWN) for debug
// ---------------------------------------------------------------------------
module baud_gen_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int SETTLE_EDGES = 2,
    parameter int MAX_HOLD     = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_i,
    input  logic [NUM_REQ-1:0]     release_i,
    input  logic [17*NUM_REQ-1:0]  req_baud_i,
    input  logic                   gen_tx_clk_i,
    output logic [16:0]            gen_baud_o,
    output logic                   gen_rst_o,
    output logic [NUM_REQ-1:0]     grant_o,
    output logic                   ready_o,
    output logic [NUM_REQ-1:0]     timeout_err_o,
    output logic [1:0]             state_o
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int EW = $clog2(SETTLE_EDGES + 1);
    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    localparam logic [16:0]   BAUD_RST    = 17'd9600;
    localparam logic [IW-1:0] PTR_RST     = IW'(NUM_REQ - 1);
    localparam logic [EW-1:0] SETTLE_LAST = EW'(SETTLE_EDGES - 1);
    localparam logic [HW-1:0] HOLD_LIMIT  = HW'(MAX_HOLD);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PROG   = 2'd1,
        S_SETTLE = 2'd2,
        S_OWN    = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [16:0]          baud_q, baud_d;
    logic [EW-1:0]        edge_cnt_q, edge_cnt_d;
    logic [HW-1:0]        hold_cnt_q, hold_cnt_d;
    logic                 tx_prev_q, tx_prev_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic                 ready_q, ready_d;
    logic                 gen_rst_q, gen_rst_d;
    logic [16:0]          gen_baud_q, gen_baud_d;
    logic [NUM_REQ-1:0]   timeout_q, timeout_d;

    logic                 tx_edge;
    logic [NUM_REQ-1:0]   owner_mask;
    logic                 own_req, own_rel, others_req;
    logic [16:0]          own_baud;
    logic [HW-1:0]        hold_next;
    logic                 hold_hit;
    logic                 win_found;
    logic [IW-1:0]        win_idx;
    logic [IW-1:0]        cand;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] i);
        onehot = NUM_REQ'(1) << i;
    endfunction

    function automatic logic [16:0] baud_of(input logic [17*NUM_REQ-1:0] bus,
                                            input logic [IW-1:0] i);
        baud_of = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (IW'(k) == i) baud_of = bus[17*k +: 17];
        end
    endfunction

    // tx_prev is held at 0 while the generator is in reset, so a tx_clk
    // that is already high when reset lifts counts as the first edge.
    assign tx_edge   = gen_tx_clk_i & ~tx_prev_q;
    assign tx_prev_d = gen_rst_q ? 1'b0 : gen_tx_clk_i;

    assign owner_mask = onehot(idx_q);
    assign own_req    = |(req_i & owner_mask);
    assign own_rel    = |(release_i & owner_mask);
    assign others_req = |(req_i & ~owner_mask);
    assign own_baud   = baud_of(req_baud_i, idx_q);

    // The hold count is kept across a baud change, so an owner cannot
    // dodge the limit by reprogramming. It saturates at the limit.
    assign hold_next = (state_q == S_OWN && tx_edge && hold_cnt_q != HOLD_LIMIT)
                       ? hold_cnt_q + 1'b1 : hold_cnt_q;
    assign hold_hit  = (MAX_HOLD > 0) && (hold_next == HOLD_LIMIT);

    // Round-robin search starting just after the last owner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        cand      = ptr_q;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IW'((int'(ptr_q) + k) % NUM_REQ);
            if (!win_found && req_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ptr_q      <= PTR_RST;
            idx_q      <= '0;
            baud_q     <= BAUD_RST;
            edge_cnt_q <= '0;
            hold_cnt_q <= '0;
            tx_prev_q  <= 1'b0;
            grant_q    <= '0;
            ready_q    <= 1'b0;
            gen_rst_q  <= 1'b1;
            gen_baud_q <= BAUD_RST;
            timeout_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            idx_q      <= idx_d;
            baud_q     <= baud_d;
            edge_cnt_q <= edge_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            tx_prev_q  <= tx_prev_d;
            grant_q    <= grant_d;
            ready_q    <= ready_d;
            gen_rst_q  <= gen_rst_d;
            gen_baud_q <= gen_baud_d;
            timeout_q  <= timeout_d;
        end
    end

    // Next-state logic. Exit priority: release/drop > timeout > baud change.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        idx_d      = idx_q;
        baud_d     = baud_q;
        edge_cnt_d = edge_cnt_q;
        hold_cnt_d = hold_cnt_q;
        timeout_d  = '0;
        unique case (state_q)
            S_IDLE: begin
                edge_cnt_d = '0;
                hold_cnt_d = '0;
                if (win_found) begin
                    idx_d   = win_idx;
                    baud_d  = baud_of(req_baud_i, win_idx);
                    state_d = S_PROG;
                end
            end
            default: begin
                hold_cnt_d = hold_next;
                if (own_rel || !own_req) begin
                    state_d = S_IDLE;
                    ptr_d   = idx_q;
                end else if (hold_hit && others_req) begin
                    timeout_d = owner_mask;
                    state_d   = S_IDLE;
                    ptr_d     = idx_q;
                end else begin
                    case (state_q)
                        S_PROG: begin
                            edge_cnt_d = '0;
                            state_d    = S_SETTLE;
                        end
                        S_SETTLE: begin
                            if (tx_edge) begin
                                if (edge_cnt_q == SETTLE_LAST) begin
                                    edge_cnt_d = '0;
                                    state_d    = S_OWN;
                                end else begin
                                    edge_cnt_d = edge_cnt_q + 1'b1;
                                end
                            end
                        end
                        S_OWN: begin
                            // Reprogram in place: grant is kept, no rearbitration.
                            if (own_baud != baud_q) begin
                                baud_d  = own_baud;
                                state_d = S_PROG;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    // Output logic: Moore outputs of the next state, registered, so every
    // output changes on the same edge as the state it belongs to.
    always_comb begin
        grant_d    = (state_d == S_IDLE) ? '0 : onehot(idx_d);
        ready_d    = (state_d == S_OWN);
        gen_rst_d  = (state_d == S_IDLE) || (state_d == S_PROG);
        gen_baud_d = (state_d == S_PROG) ? baud_d : gen_baud_q;
    end

    assign grant_o       = grant_q;
    assign ready_o       = ready_q;
    assign gen_rst_o     = gen_rst_q;
    assign gen_baud_o    = gen_baud_q;
    assign timeout_err_o = timeout_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_baud_gen_arbiter.sv
// ---------------------------------------------------------------------------
// tb_baud_gen_arbiter
//
// Bench for baud_gen_arbiter (NUM_REQ=4, SETTLE_EDGES=2, MAX_HOLD=8).
// The generator's tx_clk is driven by hand, so every settle/hold edge is
// placed exactly. A table covers the single-requester flow. Hand sequences
// cover round-robin, baud change, timeout, abort and reset.
// Outputs are sampled 1 ns after each rising clk edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_baud_gen_arbiter;

    localparam int NR = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req;
    logic [NR-1:0]   rel;
    logic [17*NR-1:0] req_baud;
    logic            gen_tx_clk;
    logic [16:0]     gen_baud;
    logic            gen_rst;
    logic [NR-1:0]   grant;
    logic            ready;
    logic [NR-1:0]   timeout_err;
    logic [1:0]      state;

    int n_cmp = 0;
    int n_err = 0;

    logic [16:0] bauds [NR];

    baud_gen_arbiter #(
        .NUM_REQ      (NR),
        .SETTLE_EDGES (2),
        .MAX_HOLD     (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_i         (req),
        .release_i     (rel),
        .req_baud_i    (req_baud),
        .gen_tx_clk_i  (gen_tx_clk),
        .gen_baud_o    (gen_baud),
        .gen_rst_o     (gen_rst),
        .grant_o       (grant),
        .ready_o       (ready),
        .timeout_err_o (timeout_err),
        .state_o       (state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_bauds();
        for (int i = 0; i < NR; i++) req_baud[17*i +: 17] = bauds[i];
    endtask

    // One tx_clk rising edge spread over two system clocks.
    task automatic tx_edge();
        gen_tx_clk = 1'b1;
        cyc();
        gen_tx_clk = 1'b0;
        cyc();
    endtask

    // req must already include requester i, which must be the next winner.
    task automatic acquire(input int i);
        logic [NR-1:0] oh;
        oh = 4'b0001 << i;
        gen_tx_clk = 1'b0;
        cyc();
        check("acq_prog_grant", grant, oh);
        check("acq_prog_rst", gen_rst, 1);
        check("acq_prog_baud", gen_baud, bauds[i]);
        check("acq_prog_ready", ready, 0);
        cyc();
        check("acq_settle_rst", gen_rst, 0);
        check("acq_settle_state", state, 2);
        tx_edge();
        check("acq_one_edge_ready", ready, 0);
        tx_edge();
        check("acq_ready", ready, 1);
        check("acq_own_grant", grant, oh);
    endtask

    // Invariants sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            check("inv_grant_onehot0", $onehot0(grant), 1);
            if (ready) begin
                check("inv_ready_grant", (grant != 0), 1);
                check("inv_ready_genrst", gen_rst, 0);
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- table ----------------
    typedef struct {
        logic [NR-1:0] req;
        logic [NR-1:0] rel;
        logic          tx;
        logic [NR-1:0] e_grant;
        logic          e_ready;
        logic          e_rst;
        logic [16:0]   e_baud;
        logic [1:0]    e_state;
    } vec_t;

    vec_t vecs [9];

    // ---------------- stimulus ----------------
    initial begin
        logic [NR-1:0] oh;

        // Single requester 0 at 57600: PROG, SETTLE, two counted edges, OWN, release.
        vecs[0] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 17'd9600,  2'd0};
        vecs[1] = '{4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b0, 1'b1, 17'd57600, 2'd1};
        vecs[2] = '{4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b0, 1'b0, 17'd57600, 2'd2};
        vecs[3] = '{4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b0, 1'b0, 17'd57600, 2'd2};
        vecs[4] = '{4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b0, 1'b0, 17'd57600, 2'd2};
        vecs[5] = '{4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b1, 1'b0, 17'd57600, 2'd3};
        vecs[6] = '{4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b1, 1'b0, 17'd57600, 2'd3};
        vecs[7] = '{4'b0001, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b1, 17'd57600, 2'd0};
        vecs[8] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 17'd57600, 2'd0};

        bauds[0] = 17'd57600;
        bauds[1] = 17'd115200;
        bauds[2] = 17'd38400;
        bauds[3] = 17'd19200;

        // ---- reset ----
        rst = 1'b1; req = '0; rel = '0; gen_tx_clk = 1'b0;
        apply_bauds();
        cyc();
        cyc();
        check("rst_grant", grant, 0);
        check("rst_ready", ready, 0);
        check("rst_genrst", gen_rst, 1);
        check("rst_baud", gen_baud, 9600);
        check("rst_timeout", timeout_err, 0);
        check("rst_state", state, 0);
        rst = 1'b0;

        // ---- table: single requester ----
        for (int v = 0; v < 9; v++) begin
            req = vecs[v].req;
            rel = vecs[v].rel;
            gen_tx_clk = vecs[v].tx;
            cyc();
            check($sformatf("vec%0d_grant", v), grant, vecs[v].e_grant);
            check($sformatf("vec%0d_ready", v), ready, vecs[v].e_ready);
            check($sformatf("vec%0d_genrst", v), gen_rst, vecs[v].e_rst);
            check($sformatf("vec%0d_baud", v), gen_baud, vecs[v].e_baud);
            check($sformatf("vec%0d_state", v), state, vecs[v].e_state);
            check($sformatf("vec%0d_timeout", v), timeout_err, 0);
        end
        rel = '0;

        // ---- round robin: fresh pointer, order 0,1,2,3,0 ----
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            acquire(n % NR);
            oh = 4'b0001 << (n % NR);
            rel = oh;
            cyc();
            rel = '0;
            check("rr_release_grant", grant, 0);
            check("rr_release_ready", ready, 0);
            check("rr_gap_genrst", gen_rst, 1);
        end
        req = '0;
        cyc();

        // ---- baud change in OWN: owner 1, 9600 -> 19200 ----
        bauds[1] = 17'd9600;
        apply_bauds();
        req = 4'b0010;
        acquire(1);
        bauds[1] = 17'd19200;
        apply_bauds();
        cyc();
        check("bc_ready_drop", ready, 0);
        check("bc_prog_state", state, 1);
        check("bc_prog_baud", gen_baud, 19200);
        check("bc_prog_genrst", gen_rst, 1);
        check("bc_prog_grant", grant, 4'b0010);
        cyc();
        check("bc_settle_state", state, 2);
        check("bc_settle_grant", grant, 4'b0010);
        tx_edge();
        check("bc_edge1_ready", ready, 0);
        check("bc_edge1_grant", grant, 4'b0010);
        tx_edge();
        check("bc_ready_back", ready, 1);
        check("bc_own_grant", grant, 4'b0010);
        check("bc_own_baud", gen_baud, 19200);
        req = '0;
        cyc();
        check("bc_drop_grant", grant, 0);

        // ---- timeout: owner 2 holds while requester 3 waits ----
        req = 4'b1100;
        acquire(2);
        for (int n = 0; n < 7; n++) begin
            tx_edge();
            check("to_quiet", timeout_err, 0);
            check("to_hold_grant", grant, 4'b0100);
        end
        gen_tx_clk = 1'b1;
        cyc();
        check("to_pulse", timeout_err, 4'b0100);
        check("to_grant_drop", grant, 0);
        check("to_state_idle", state, 0);
        gen_tx_clk = 1'b0;
        cyc();
        check("to_pulse_end", timeout_err, 0);
        check("to_next_owner", grant, 4'b1000);
        check("to_next_baud", gen_baud, bauds[3]);
        req = 4'b0100;
        cyc();
        check("to_owner3_drop", grant, 0);

        // ---- hold limit with nobody waiting: ownership kept, counter saturates ----
        acquire(2);
        for (int n = 0; n < 10; n++) begin
            tx_edge();
            check("sat_no_pulse", timeout_err, 0);
        end
        check("sat_grant_kept", grant, 4'b0100);
        check("sat_ready_kept", ready, 1);
        req = 4'b1100;
        cyc();
        check("sat_late_pulse", timeout_err, 4'b0100);
        cyc();
        check("sat_next_owner", grant, 4'b1000);
        req = '0;
        cyc();
        cyc();

        // ---- abort in SETTLE ----
        req = 4'b0001;
        cyc();
        check("ab_prog_grant", grant, 4'b0001);
        cyc();
        check("ab_settle_state", state, 2);
        tx_edge();
        check("ab_settle_ready", ready, 0);
        req = '0;
        cyc();
        check("ab_idle_state", state, 0);
        check("ab_idle_grant", grant, 0);
        check("ab_idle_ready", ready, 0);
        check("ab_idle_genrst", gen_rst, 1);
        check("ab_no_timeout", timeout_err, 0);

        // ---- release and new request in the same cycle ----
        req = 4'b0001;
        acquire(0);
        rel = 4'b0001;
        req = 4'b0011;
        cyc();
        rel = '0;
        check("rr2_idle_grant", grant, 0);
        check("rr2_idle_state", state, 0);
        cyc();
        check("rr2_next_grant", grant, 4'b0010);
        req = '0;
        cyc();
        cyc();

        // ---- reset in OWN ----
        req = 4'b0100;
        acquire(2);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("mr_grant", grant, 0);
        check("mr_ready", ready, 0);
        check("mr_genrst", gen_rst, 1);
        check("mr_baud", gen_baud, 9600);
        check("mr_timeout", timeout_err, 0);
        check("mr_state", state, 0);
        req = 4'b1111;
        cyc();
        check("mr_first_prio", grant, 4'b0001);
        check("mr_first_baud", gen_baud, bauds[0]);
        req = '0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
